// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding and timing defaults for the Morse player
package morse_pkg;
    typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, DONE} state_t;
    localparam int DOT_UNITS = 1;
    localparam int DEF_DASH_UNITS = 3;
    localparam int DEF_LGAP_UNITS = 3;
    localparam int DEF_MAX_LEN = 5;
endpackage

// File: rtl/morse_unit_counter.sv
// morse_unit_counter: counts unit ticks toward a target, flags the terminating tick
module morse_unit_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         tick,
    input  logic [W-1:0] target,
    output logic         hit
);
    logic [W-1:0] count;
    assign hit = tick && ({1'b0, count} + (W+1)'(1) >= {1'b0, target});
    // clear on load, otherwise count ticks and saturate instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst || load) count <= '0;
        else if (tick && count != '1) count <= count + W'(1);
    end
endmodule

// File: rtl/morse_tx_player.sv
// morse_tx_player: plays one latched Morse letter on led_out, paced by UnitTick
module morse_tx_player
    import morse_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int DASH_UNITS = DEF_DASH_UNITS,
    parameter int LGAP_UNITS = DEF_LGAP_UNITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [2:0]         length,
    input  logic               abort,
    input  logic               UnitTick,
    output logic               led_out,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(((DASH_UNITS > LGAP_UNITS) ? DASH_UNITS : LGAP_UNITS) + 1);
    state_t state, next;
    logic [MAX_LEN-1:0] pat_q;
    logic [2:0] len_q, idx, len_c;
    logic [CW-1:0] target;
    logic hit, accept, last, led_d, busy_d, done_d;
    assign accept = state == IDLE && start && !abort;
    assign last = idx == len_q - 3'd1;
    assign len_c = (length > 3'(MAX_LEN)) ? 3'(MAX_LEN) : length;
    // unit budget for the current state; dot/dash picked by the current element bit
    always_comb begin
        target = (state == MARK && pat_q[idx]) ? CW'(DASH_UNITS) :
                 (state == LGAP) ? CW'(LGAP_UNITS) : CW'(DOT_UNITS);
    end
    morse_unit_counter #(.W(CW)) u_cnt (
        .clk(clk), .rst(rst), .load(next != state), .tick(UnitTick),
        .target(target), .hit(hit)
    );
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            led_out <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= next;
            led_out <= led_d;
            busy <= busy_d;
            done <= done_d;
        end
    end
    // next-state: abort beats every tick, start only honoured in IDLE
    always_comb begin
        next = state;
        unique case (state)
            IDLE: next = accept ? ((len_c == 3'd0) ? DONE : MARK) : IDLE;
            MARK: next = abort ? IDLE : hit ? (last ? LGAP : GAP) : MARK;
            GAP:  next = abort ? IDLE : hit ? MARK : GAP;
            LGAP: next = abort ? IDLE : hit ? DONE : LGAP;
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end
    // outputs derived from the upcoming state so they register in step with it
    always_comb begin
        led_d = next == MARK;
        busy_d = next != IDLE;
        done_d = next == DONE;
    end
    // letter latch and element index, which moves on only when a mark ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx <= '0;
        end else if (accept) begin
            pat_q <= pattern;
            len_q <= len_c;
            idx <= '0;
        end else if (state == MARK && (next == GAP || next == LGAP)) begin
            idx <= idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_morse_tx_player.sv
// tb_morse_tx_player: scoreboard bench comparing led_out per unit against an expected unit stream
module tb_morse_tx_player;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, UnitTick = 1'b0;
    logic [4:0] pattern = '0;
    logic [2:0] length = '0;
    logic led_out, busy, done;
    int checks = 0, fails = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    morse_tx_player dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .length(length),
        .abort(abort), .UnitTick(UnitTick), .led_out(led_out), .busy(busy), .done(done)
    );

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1; length = 3'd1; UnitTick = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; UnitTick = 1'b0;
        checks++;
        if (led_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset: led=%b busy=%b done=%b, required 0 0 0", led_out, busy, done);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: busy=%b, required 0", busy);
        end
    endtask

    task automatic play(input logic [4:0] pat, input logic [2:0] len, input bit tick_on_start, input string name);
        int n;
        bit e;
        n = (len > 3'd5) ? 5 : int'(len);
        for (int i = 0; i < n; i++) begin
            repeat (pat[i] ? 3 : 1) exp_q.push_back(1'b1);
            repeat ((i == n - 1) ? 3 : 1) exp_q.push_back(1'b0);
        end
        @(negedge clk);
        start = 1'b1; pattern = pat; length = len; UnitTick = tick_on_start;
        @(negedge clk);
        start = 1'b0; UnitTick = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s unit %0d: led=%b busy=%b done=%b, required led=%b busy=1 done=0",
                         name, exp_q.size(), led_out, busy, done, e);
            end
            UnitTick = 1'b1;
            @(negedge clk);
            UnitTick = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || led_out !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s done_pulse: done=%b led=%b busy=%b, required 1 0 1", name, done, led_out, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_letters();
        play(5'b00000, 3'd1, 1'b0, "E");
        play(5'b00010, 3'd2, 1'b0, "A");
        play(5'b00000, 3'd0, 1'b0, "len0");
        play(5'b11111, 3'd7, 1'b0, "clamp");
    endtask

    task automatic test_back_to_back();
        play(5'b00101, 3'd3, 1'b0, "K");
        play(5'b00001, 3'd1, 1'b1, "T_tick_on_start");
        play(5'b01001, 3'd5, 1'b1, "mixed");
    endtask

    task automatic test_abort();
        bit bad;
        @(negedge clk);
        start = 1'b1; pattern = 5'b00001; length = 3'd1;
        @(negedge clk);
        start = 1'b0; UnitTick = 1'b1;
        @(negedge clk);
        UnitTick = 1'b0;
        start = 1'b1; pattern = 5'b00000; length = 3'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (led_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_mark: led=%b busy=%b done=%b, required 1 1 0", led_out, busy, done);
        end
        abort = 1'b1; UnitTick = 1'b1;
        @(negedge clk);
        abort = 1'b0; UnitTick = 1'b0;
        checks++;
        if (led_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_mid_dash: led=%b busy=%b done=%b, required 0 0 0", led_out, busy, done);
        end
        bad = 1'b0;
        repeat (6) begin
            UnitTick = 1'b1;
            @(negedge clk);
            UnitTick = 1'b0;
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || led_out !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL abort_no_done: activity after abort, required none");
        end
        abort = 1'b1; start = 1'b1; pattern = 5'b00000; length = 3'd1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || led_out !== 1'b0) begin
            fails++;
            $display("FAIL abort_start_idle: busy=%b led=%b, required 0 0", busy, led_out);
        end
    endtask

    task automatic test_reset_gap();
        bit bad;
        @(negedge clk);
        start = 1'b1; pattern = 5'b00000; length = 3'd2;
        @(negedge clk);
        start = 1'b0; UnitTick = 1'b1;
        @(negedge clk);
        UnitTick = 1'b0;
        checks++;
        if (led_out !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL in_gap: led=%b busy=%b, required 0 1", led_out, busy);
        end
        rst = 1'b0; UnitTick = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b1; UnitTick = 1'b0; start = 1'b0;
        checks++;
        if (led_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_gap: led=%b busy=%b done=%b, required 0 0 0", led_out, busy, done);
        end
        bad = 1'b0;
        repeat (8) begin
            UnitTick = 1'b1;
            @(negedge clk);
            UnitTick = 1'b0;
            if (done !== 1'b0 || busy !== 1'b0 || led_out !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL no_resume: playback after reset, required idle");
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_back_to_back();
        test_abort();
        test_reset_gap();
        play(5'b00110, 3'd4, 1'b0, "after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
